// File: rtl/result_collector_pkg.sv
// Shared NoC packet definitions used by PE, router and result collector.
package result_collector_pkg;

  localparam int PKT_W  = 32;
  localparam int DATA_W = 13;

  localparam int TYPE_LSB  = 29;
  localparam int DSTY_LSB  = 24;
  localparam int DSTX_LSB  = 21;
  localparam int SRCY_LSB  = 16;
  localparam int SRCX_LSB  = 13;
  localparam int PSUM_LSB  = 0;

  typedef enum logic [2:0] {
    PKT_FILTER = 3'b000,
    PKT_IFMAP  = 3'b001,
    PKT_PSUM   = 3'b010,
    PKT_RESULT = 3'b011
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e          ptype;
    logic [4:0]         dst_y;
    logic [2:0]         dst_x;
    logic [4:0]         src_y;
    logic [2:0]         src_x;
    logic [DATA_W-1:0]  psum;
  } pkt_t;

  function automatic logic [PKT_W-1:0] make_pkt(
    input logic [2:0]        ptype,
    input logic [4:0]        src_y,
    input logic [DATA_W-1:0] psum
  );
    return {ptype, 5'd0, 3'd0, src_y, 3'd0, psum};
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// Valid/ready packet channel from the NoC into the collector.
interface result_collector_if #(
  parameter int WIDTH_PKT = 32
);

  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [WIDTH_PKT-1:0] pkt_data;

  modport master (
    output pkt_valid,
    output pkt_data,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_data,
    output pkt_ready
  );

endinterface

// File: rtl/result_mem.sv
// Result storage: one write port, one registered read port.
module result_mem #(
  parameter int DEPTH = 105,
  parameter int WIDTH = 13,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/result_collector.sv
// Collects final psum results per PE row into a flat buffer,
// then serves readout once every row has delivered DEPTH_R results.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int WIDTH_PKT  = PKT_W,
  parameter int WIDTH_DATA = DATA_W,
  parameter int NUM_ROWS   = 5,
  parameter int DEPTH_R    = 21,
  localparam int TOTAL     = NUM_ROWS * DEPTH_R,
  localparam int AW        = $clog2(TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst,
  result_collector_if.slave     pkt,
  input  logic                  clear,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH_DATA-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err_drop
);

  localparam int CW = $clog2(DEPTH_R + 1);
  localparam int TW = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH_R);
  localparam logic [TW-1:0] LAST_T  = TW'(TOTAL - 1);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH_R);
  localparam logic [AW-1:0] TOTAL_A = AW'(TOTAL);

  typedef enum logic {
    COLLECT,
    DONE
  } state_e;

  state_e state, state_nx;

  logic [CW-1:0]         row_cnt [NUM_ROWS];
  logic [TW-1:0]         total;
  pkt_t                  p;
  logic                  accept;
  logic                  store;
  logic                  drop;
  logic                  row_ok;
  logic [CW-1:0]         cnt_sel;
  logic [AW-1:0]         wr_addr;
  logic                  rd_hit;
  logic [WIDTH_DATA-1:0] rd_q;
  logic                  unused_fields;

  assign p = pkt_t'(pkt.pkt_data);
  assign unused_fields = ^{p.dst_y, p.dst_x, p.src_x};

  // Ready is withheld during reset and the clear cycle.
  assign pkt.pkt_ready = !rst && !clear && (state == COLLECT);
  assign accept = pkt.pkt_valid && pkt.pkt_ready;

  always_comb begin
    cnt_sel = '0;
    row_ok  = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (p.src_y == 5'(r)) begin
        cnt_sel = row_cnt[r];
        row_ok  = 1'b1;
      end
    end
  end

  assign store = accept && (p.ptype == PKT_RESULT) &&
                 row_ok && (cnt_sel < CNT_MAX);
  assign drop  = accept && !store;

  assign wr_addr = AW'(AW'(p.src_y) * DEPTH_A + AW'(cnt_sel));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (store && total == LAST_T) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) row_cnt[r] <= '0;
      total    <= '0;
      err_drop <= 1'b0;
    end else if (clear) begin
      for (int r = 0; r < NUM_ROWS; r++) row_cnt[r] <= '0;
      total    <= '0;
      err_drop <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (store && p.src_y == 5'(r)) row_cnt[r] <= row_cnt[r] + CW'(1);
      end
      if (store) total <= total + TW'(1);
      if (drop)  err_drop <= 1'b1;
    end
  end

  assign done   = (state == DONE);
  assign rd_hit = rd_en && (state == DONE) && (rd_addr < TOTAL_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= rd_hit;
  end

  assign rd_data = rd_valid ? rd_q : '0;

  result_mem #(
    .DEPTH (TOTAL),
    .WIDTH (WIDTH_DATA),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (wr_addr),
    .wr_data (p.psum),
    .rd_en   (rd_hit),
    .rd_addr (rd_addr),
    .rd_q    (rd_q)
  );

endmodule

// File: tb/tb_result_collector.sv
// Directed checks for result_collector: fill, drops, clear, reset, readout.
module tb_result_collector;
  import result_collector_pkg::*;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [12:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err_drop;

  int nchk;
  int nerr;

  result_collector_if #(.WIDTH_PKT(32)) bus ();

  result_collector dut (
    .clk      (clk),
    .rst      (rst),
    .pkt      (bus),
    .clear    (clear),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .err_drop (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Entered and left on a falling edge; one transfer cycle in COLLECT.
  task automatic send(input logic [2:0] t, input int y, input int v);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = make_pkt(t, 5'(y), 13'(v));
    @(negedge clk);
    bus.pkt_valid = 1'b0;
  endtask

  task automatic full_pass(input int base, input string tag);
    for (int i = 0; i < 105; i++) begin
      send(3'b011, i % 5, base + (i % 5) * 100 + i / 5);
      if (i == 103) check({tag, "_done_early"}, done, 1'b0);
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic read_one(input int a, input int exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = 7'(a);
    @(negedge clk);
    check({tag, "_vld"}, rd_valid, 1'b1);
    check({tag, "_dat"}, rd_data, 32'(exp));
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst = 1'b1;
    clear = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    bus.pkt_valid = 1'b0;
    bus.pkt_data = '0;

    @(negedge clk);
    check("rst_ready", bus.pkt_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_drop, 1'b0);
    check("rst_rvld", rd_valid, 1'b0);
    check("rst_rdat", rd_data, 0);
    rst = 1'b0;
    #1 check("post_rst_ready", bus.pkt_ready, 1'b1);
    @(negedge clk);

    // Readout request while collecting is ignored.
    rd_en = 1'b1;
    rd_addr = 7'd3;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_collect_vld", rd_valid, 1'b0);
    check("rd_collect_dat", rd_data, 0);

    // Wrong type and out-of-range row are consumed without storing.
    check("err_before", err_drop, 1'b0);
    send(3'b010, 0, 13'h1abc);
    check("err_type", err_drop, 1'b1);
    send(3'b011, 6, 13'h0abc);
    check("err_row_done", done, 1'b0);

    // Counters untouched: done lands exactly on the 105th result.
    full_pass(0, "p1");
    check("p1_err_sticky", err_drop, 1'b1);
    read_one(2 * 21 + 7, 207, "rd49");
    read_one(0, 0, "rd0");
    read_one(104, 420, "rd104");
    read_one(21, 100, "rd21");
    read_one(83, 320, "rd83");
    rd_addr = 7'd105;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd105_vld", rd_valid, 1'b0);
    check("rd105_dat", rd_data, 0);

    // Backpressure in DONE, then clear with a packet pending.
    bus.pkt_valid = 1'b1;
    bus.pkt_data = make_pkt(3'b011, 5'd0, 13'd555);
    #1 check("done_ready0", bus.pkt_ready, 1'b0);
    @(negedge clk);
    check("done_ready1", bus.pkt_ready, 1'b0);
    check("done_hold", done, 1'b1);
    clear = 1'b1;
    #1 check("clr_ready", bus.pkt_ready, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    bus.pkt_valid = 1'b0;
    #1;
    check("clr_ready_after", bus.pkt_ready, 1'b1);
    check("clr_done", done, 1'b0);
    check("clr_err", err_drop, 1'b0);
    @(negedge clk);

    // Row overflow: 22nd result for row 0 is dropped.
    for (int c = 0; c < 22; c++) begin
      send(3'b011, 0, 7000 + c);
      if (c == 20) check("ovf_err_21", err_drop, 1'b0);
    end
    check("ovf_err_22", err_drop, 1'b1);
    check("ovf_done", done, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr2_err", err_drop, 1'b0);

    // Reset mid-pass, then a fresh full pass.
    for (int i = 0; i < 50; i++)
      send(3'b011, i % 5, 4000 + (i % 5) * 100 + i / 5);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_ready", bus.pkt_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_done", done, 1'b0);
    full_pass(2000, "p2");
    read_one(49, 2207, "p2_rd49");
    read_one(0, 2000, "p2_rd0");
    read_one(104, 2420, "p2_rd104");
    rd_en = 1'b0;
    @(negedge clk);
    check("p2_rd_idle", rd_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
